gin_xbus_mc: RTL and testbench

GIN_XBUS_MC -- requirements
Module: gin_xbus_mc

---
 rtl/gin_xbus_mc.sv | 103 ++++++++++
 tb/tb_gin_xbus_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gin_xbus_mc.sv
// Tag-routed multicast bus: one upstream port fans out to per-column FIFOs.
// Column IDs are loaded through a serial scan chain.
module gin_xbus_mc #(
   parameter int DATA_WIDTH    = 64,
   parameter int COL_TAG_WIDTH = 4,
   parameter int NUM_OF_COLS   = 14,
   parameter int BUF_DEPTH     = 2
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [DATA_WIDTH-1:0]                   data_in,
   input  logic [COL_TAG_WIDTH-1:0]                col_tag,
   input  logic                                    bcast_in,
   input  logic                                    enable_in,
   output logic                                    ready_up,
   output logic [NUM_OF_COLS-1:0][DATA_WIDTH-1:0]  data_out,
   output logic [NUM_OF_COLS-1:0]                  enable_out,
   input  logic [NUM_OF_COLS-1:0]                  ready_in,
   input  logic                                    se_id,
   input  logic                                    si_id,
   output logic                                    so_id,
   output logic                                    drop_flag
);

   localparam int PW    = $clog2(BUF_DEPTH);
   localparam int CW    = PW + 1;
   localparam int CHAIN = NUM_OF_COLS * COL_TAG_WIDTH;

   logic [NUM_OF_COLS-1:0][COL_TAG_WIDTH-1:0] col_id_q, col_id_d;
   logic [DATA_WIDTH-1:0] mem_q    [NUM_OF_COLS][BUF_DEPTH];
   logic [PW-1:0]         rd_ptr_q [NUM_OF_COLS];
   logic [PW-1:0]         wr_ptr_q [NUM_OF_COLS];
   logic [CW-1:0]         count_q  [NUM_OF_COLS];
   logic                  drop_q;

   logic [NUM_OF_COLS-1:0] match, full, push, pop;
   logic [CHAIN-1:0]       id_flat;
   logic                   accept;

   always_comb begin
      match      = '0;
      full       = '0;
      pop        = '0;
      enable_out = '0;
      data_out   = '0;
      for (int i = 0; i < NUM_OF_COLS; i++) begin
         match[i]      = bcast_in | (col_id_q[i] == col_tag);
         full[i]       = (count_q[i] == CW'(BUF_DEPTH));
         enable_out[i] = (count_q[i] != '0);
         pop[i]        = enable_out[i] & ready_in[i];
         data_out[i]   = mem_q[i][rd_ptr_q[i]];
      end
      // Fullness uses current occupancy only; a same-cycle pop does not free a slot.
      ready_up = ~se_id & ~|(match & full);
      accept   = enable_in & ready_up;
      push     = accept ? match : '0;

      id_flat = col_id_q;
      if (se_id) begin
         id_flat = {id_flat[CHAIN-2:0], si_id};
      end
      col_id_d = id_flat;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_id_q <= '0;
         drop_q   <= 1'b0;
         for (int i = 0; i < NUM_OF_COLS; i++) begin
            rd_ptr_q[i] <= '0;
            wr_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         col_id_q <= col_id_d;
         if (accept && (match == '0)) begin
            drop_q <= 1'b1;
         end
         for (int i = 0; i < NUM_OF_COLS; i++) begin
            if (push[i]) begin
               wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            end
            if (pop[i]) begin
               rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
            count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
         end
      end
   end

   // Storage needs no reset: an empty column never exposes its contents as valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_OF_COLS; i++) begin
         if (push[i]) begin
            mem_q[i][wr_ptr_q[i]] <= data_in;
         end
      end
   end

   assign so_id     = col_id_q[NUM_OF_COLS-1][COL_TAG_WIDTH-1];
   assign drop_flag = drop_q;

endmodule

// File: tb/tb_gin_xbus_mc.sv
// Bench for gin_xbus_mc: directed scenarios, a vector table for the
// backpressure case, and a randomized run against a queue-based model.
module tb_gin_xbus_mc;

   localparam int DW = 64;
   localparam int TW = 4;
   localparam int NC = 14;
   localparam int BD = 2;
   localparam int CL = NC * TW;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [DW-1:0]          data_in;
   logic [TW-1:0]          col_tag;
   logic                   bcast_in, enable_in, ready_up;
   logic [NC-1:0][DW-1:0]  data_out;
   logic [NC-1:0]          enable_out, ready_in;
   logic                   se_id, si_id, so_id, drop_flag;

   int n_vec = 0;
   int n_err = 0;

   // Model: one queue per column, the scan chain as a flat bit array.
   logic [DW-1:0] mq[NC][$];
   bit            chain[CL];
   bit            m_drop;

   gin_xbus_mc #(.DATA_WIDTH(DW), .COL_TAG_WIDTH(TW), .NUM_OF_COLS(NC), .BUF_DEPTH(BD)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .col_tag(col_tag),
      .bcast_in(bcast_in), .enable_in(enable_in), .ready_up(ready_up),
      .data_out(data_out), .enable_out(enable_out), .ready_in(ready_in),
      .se_id(se_id), .si_id(si_id), .so_id(so_id), .drop_flag(drop_flag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          en;
      logic [DW-1:0] d;
      logic          rdy3;
      logic          exp_ru;
      logic          exp_en3;
      logic [DW-1:0] exp_d3;
   } vec_t;

   function automatic int m_id(int c);
      int v = 0;
      for (int b = 0; b < TW; b++) v += int'(chain[c*TW+b]) << b;
      return v;
   endfunction

   function automatic bit m_match(int c, logic bc, logic [TW-1:0] tag);
      return bc || (m_id(c) == int'(tag));
   endfunction

   function automatic bit m_ready(logic se, logic bc, logic [TW-1:0] tag);
      if (se) return 1'b0;
      for (int c = 0; c < NC; c++)
         if (m_match(c, bc, tag) && mq[c].size() >= BD) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_reset();
      for (int c = 0; c < NC; c++) mq[c].delete();
      for (int p = 0; p < CL; p++) chain[p] = 1'b0;
      m_drop = 1'b0;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("ready_up", ready_up, m_ready(se_id, bcast_in, col_tag));
      for (int c = 0; c < NC; c++) begin
         chk($sformatf("enable_out[%0d]", c), enable_out[c], mq[c].size() > 0);
         if (mq[c].size() > 0) chk($sformatf("data_out[%0d]", c), data_out[c], mq[c][0]);
      end
      chk("drop_flag", drop_flag, m_drop);
      chk("so_id", so_id, chain[CL-1]);
   endtask

   // One clock: drive inputs, check against model before the edge, advance the model.
   task automatic cyc(input logic rst, input logic en, input logic bc, input logic se,
                      input logic si, input logic [TW-1:0] tag, input logic [DW-1:0] d,
                      input logic [NC-1:0] rdy, output logic ru);
      bit acc, any;
      reset = rst; enable_in = en; bcast_in = bc; se_id = se; si_id = si;
      col_tag = tag; data_in = d; ready_in = rdy;
      @(negedge clk);
      ru = ready_up;
      check_model();
      acc = en && m_ready(se, bc, tag);
      @(posedge clk);
      if (rst) begin
         m_reset();
      end else begin
         any = 1'b0;
         for (int c = 0; c < NC; c++)
            if (mq[c].size() > 0 && rdy[c]) void'(mq[c].pop_front());
         for (int c = 0; c < NC; c++)
            if (acc && m_match(c, bc, tag)) begin
               mq[c].push_back(d);
               any = 1'b1;
            end
         if (acc && !any) m_drop = 1'b1;
         if (se) begin
            for (int p = CL - 1; p > 0; p--) chain[p] = chain[p-1];
            chain[0] = si;
         end
      end
      #1;
   endtask

   initial begin
      vec_t tbl[7];
      logic ru;
      int   p;

      // Column 3 (ID 3) with BUF_DEPTH 2: third transfer stalls, no bypass on pop.
      tbl[0] = '{1'b1, 64'h301, 1'b0, 1'b1, 1'b1, 64'h301};
      tbl[1] = '{1'b1, 64'h302, 1'b0, 1'b1, 1'b1, 64'h301};
      tbl[2] = '{1'b1, 64'h303, 1'b0, 1'b0, 1'b1, 64'h301};
      tbl[3] = '{1'b1, 64'h303, 1'b1, 1'b0, 1'b1, 64'h302};
      tbl[4] = '{1'b1, 64'h303, 1'b0, 1'b1, 1'b1, 64'h302};
      tbl[5] = '{1'b0, 64'h0,   1'b1, 1'b0, 1'b1, 64'h303};
      tbl[6] = '{1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 64'h0};

      reset = 1'b1; enable_in = 1'b0; bcast_in = 1'b0; se_id = 1'b0; si_id = 1'b0;
      col_tag = '0; data_in = '0; ready_in = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;

      cyc(0, 0, 0, 0, 0, 4'd0, 64'h0, 14'h0, ru);
      chk("rst_ready_up", ru, 1'b1);
      chk("rst_enable_out", enable_out, 14'h0);
      chk("rst_drop", drop_flag, 1'b0);
      chk("rst_so_id", so_id, 1'b0);

      // Scan col_id[i] = i; first bit scanned lands at the chain MSB.
      for (int k = 0; k < CL; k++) begin
         p = CL - 1 - k;
         cyc(0, 0, 0, 1, 1'(((p / TW) >> (p % TW)) & 1), 4'd0, 64'h0, 14'h0, ru);
      end
      chk("scan_so_first_bit", so_id, 1'b1);
      cyc(0, 1, 0, 0, 0, 4'd5, 64'hA5, 14'h0, ru);
      chk("tag5_ready", ru, 1'b1);
      chk("tag5_enable_out", enable_out, 14'h0020);
      chk("tag5_data", data_out[5], 64'hA5);
      cyc(0, 0, 0, 0, 0, 4'd0, 64'h0, 14'h3FFF, ru);

      cyc(0, 1, 1, 0, 0, 4'd0, 64'h11, 14'h0, ru);
      chk("bcast1_ready", ru, 1'b1);
      chk("bcast1_enable_out", enable_out, 14'h3FFF);
      cyc(0, 1, 1, 0, 0, 4'd0, 64'h22, 14'h0, ru);
      chk("bcast2_ready", ru, 1'b1);
      cyc(0, 1, 1, 0, 0, 4'd0, 64'h33, 14'h0, ru);
      chk("bcast3_blocked", ru, 1'b0);
      cyc(0, 0, 0, 0, 0, 4'd0, 64'h0, 14'h3FFF, ru);
      cyc(0, 1, 1, 0, 0, 4'd0, 64'h33, 14'h0, ru);
      chk("bcast3_after_pop", ru, 1'b1);
      chk("bcast_head7", data_out[7], 64'h22);
      repeat (3) cyc(0, 0, 0, 0, 0, 4'd0, 64'h0, 14'h3FFF, ru);

      for (int k = 0; k < 7; k++) begin
         cyc(0, tbl[k].en, 0, 0, 0, 4'd3, tbl[k].d, tbl[k].rdy3 ? 14'h0008 : 14'h0, ru);
         chk($sformatf("bp%0d_ready", k), ru, tbl[k].exp_ru);
         chk($sformatf("bp%0d_en3", k), enable_out[3], tbl[k].exp_en3);
         if (tbl[k].exp_en3) chk($sformatf("bp%0d_data3", k), data_out[3], tbl[k].exp_d3);
      end

      cyc(0, 1, 0, 0, 0, 4'd15, 64'hDEAD, 14'h0, ru);
      chk("drop_ready", ru, 1'b1);
      chk("drop_enable_out", enable_out, 14'h0);
      chk("drop_set", drop_flag, 1'b1);
      repeat (3) cyc(0, 0, 0, 0, 0, 4'd0, 64'h0, 14'h0, ru);
      chk("drop_sticky", drop_flag, 1'b1);
      cyc(1, 0, 0, 0, 0, 4'd0, 64'h0, 14'h0, ru);
      chk("drop_cleared", drop_flag, 1'b0);

      // Reset with half-full columns, scan active and a transfer presented.
      cyc(0, 1, 0, 0, 0, 4'd0, 64'h37, 14'h0, ru);
      cyc(0, 1, 0, 0, 0, 4'd15, 64'h38, 14'h0, ru);
      repeat (5) cyc(0, 0, 0, 1, 1, 4'd0, 64'h0, 14'h0, ru);
      cyc(1, 1, 0, 1, 1, 4'd0, 64'h39, 14'h3FFF, ru);
      chk("rst2_enable_out", enable_out, 14'h0);
      chk("rst2_drop", drop_flag, 1'b0);
      chk("rst2_so_id", so_id, 1'b0);
      cyc(0, 0, 0, 1, 0, 4'd0, 64'h0, 14'h0, ru);
      chk("rst2_ready_se", ru, 1'b0);
      cyc(0, 1, 0, 0, 0, 4'd0, 64'h3A, 14'h0, ru);
      chk("rst2_ids_zero", enable_out, 14'h3FFF);
      repeat (2) cyc(0, 0, 0, 0, 0, 4'd0, 64'h0, 14'h3FFF, ru);

      for (int k = 0; k < 3000; k++) begin
         cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 1'($urandom),
             4'($urandom), {$urandom, $urandom}, 14'($urandom), ru);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
